ser_frame_tx: RTL
=================

Name: ser_frame_tx

Overview:
- Serial frame generator that sits directly upstream of the port demultiplexer top level.
- Accepts a port number, a data count and a data word via a level request/ready handshake.
- Drives the single serial line (idle-high) that the demux consumes on its SerIn input.
- Bit timing advances only on Clk_EN-qualified clock edges, matching the demux's single-step/pushbutton-enabled timing.

Parameters:
- CNT_W, 4, width of the data-count field; max data bits per frame = 2**CNT_W - 1.
- DATA_W, 15, width of data_in; must be >= 2**CNT_W - 1.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Clk_EN  input  1  bit-step enable; one serial bit period = interval between two enabled edges.
- start  input  1  level request; held until accepted.
- port_in  input  2  destination port number (0..3).
- len_in  input  CNT_W  number of data bits N to send.
- data_in  input  DATA_W  payload; bits data_in[N-1:0] are sent.
- ready  output  1  high in IDLE; request accepted when start & ready & Clk_EN at a clk edge.
- busy  output  1  high from acceptance until frame end.
- SerOut  output  1  serial line to the demux SerIn; idle 1.
- done  output  1  one-clk pulse at frame end.

Behaviour:
- Frame format, bits in order:
  - start bit 0;
  - port_in[1:0], MSB first;
  - len_in, MSB first;
  - N data bits data_in[N-1] down to data_in[0];
  - the line then returns to 1.
  - Frame length = 3 + CNT_W + N bits.
- Reset (async): state IDLE, SerOut=1, ready=1, busy=0, done=0, bit counter 0, holding registers 0. Reset mid-frame aborts immediately; SerOut goes to 1 without waiting for clk.
- States:
  - IDLE: on edge with start & Clk_EN: latch port/len/data into holding registers, SerOut<=0, go to START.
  - START: on Clk_EN edge: SerOut<=port[1], go to PORT (counter=1).
  - PORT: each Clk_EN edge emits the next port bit. After port[0] has been held one period, emit len MSB and go to LEN.
  - LEN: emits CNT_W bits. After the last len bit:
    - if N>0, emit data[N-1] and go to DATA;
    - if N==0, SerOut<=1, pulse done, go to IDLE.
  - DATA: emits bits down to data[0]. On the next Clk_EN edge: SerOut<=1, done<=1 for one clk, return to IDLE.
- ready=1 only in IDLE; busy = ~ready.
- Holding registers are frozen while busy; input changes during a frame have no effect.
- start while busy is ignored (not queued).
- start may be re-asserted in the same clk as done; it is accepted at the next edge where state=IDLE and Clk_EN=1.
- Clk_EN low: all state and SerOut hold; done never asserts without Clk_EN.
- Latency: first start bit appears on the accepting edge; done pulses exactly 3+CNT_W+N enabled edges after acceptance.
- len_in=0 is legal (header-only frame). Bit index counter width must be >= CNT_W.

Optional Feature:
- Macro TX_PARITY_EN.
- When defined: one extra bit, even parity (XOR of the N data bits; 0 when N=0), is sent after the last data bit and before the return to 1. Frame length = 4 + CNT_W + N; done is delayed one enabled edge.
- When undefined: no parity bit; frame exactly as above.

Test Plan:
- Reset held 50ns, Clk_EN=1 -> SerOut=1, ready=1, busy=0, done=0. Assert rst mid-frame -> SerOut=1 asynchronously, ready=1.
- port_in=2, len_in=3, data_in=3'b101, start pulse with Clk_EN=1 every clk -> SerOut sequence 0,1,0,0,0,1,1,1,0,1 then 1. done pulses on 10th edge after acceptance.
- port_in=1, len_in=0 -> SerOut 0,0,1,0,0,0,0 then 1. done after 7 enabled edges.
- Clk_EN high 1 clk in every 4 during the scenario 2 frame -> each bit held exactly 4 clks; same bit sequence; done after 40 clks.
- start held continuously with inputs changed mid-frame -> second frame begins only after done, carrying the new values; the first frame is unaffected.
- TX_PARITY_EN defined, scenario 2 -> extra bit 0 after data, done on 11th edge; data 3'b100 -> parity bit 1.

Source files
------------

// File: rtl/ser_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ser_frame_tx : serial frame generator (start, port, length, data) feeding |
// | the port demux SerIn line; optional TX_PARITY_EN adds an even parity bit. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ser_frame_tx #(
  parameter int CNT_W  = 4,
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Clk_EN,
  input  logic              start,
  input  logic [1:0]        port_in,
  input  logic [CNT_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              busy,
  output logic              SerOut,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_PORT  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]  c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_len_top = CNT_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0]  c_len_lsb = CNT_W'(1);
  localparam logic [DATA_W-1:0] c_dat_lsb = DATA_W'(1);

  state_t              r_state;
  logic [1:0]          r_port;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_ser;
  logic                r_ready;
  logic                r_done;
`ifdef TX_PARITY_EN
  logic                r_par;
`endif

  // r_cnt counts the bits still to follow the one currently on the line.
  logic [CNT_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_len_sh;
  logic [DATA_W-1:0] w_dat_sh;
  logic [DATA_W-1:0] w_first_sh;
  logic              w_len_bit;
  logic              w_dat_bit;
  logic              w_first_bit;

  assign w_idx       = r_cnt - c_one;
  assign w_len_sh    = r_len >> w_idx;
  assign w_dat_sh    = r_data >> w_idx;
  assign w_first_sh  = r_data >> (r_len - c_one);
  assign w_len_bit   = |(w_len_sh & c_len_lsb);
  assign w_dat_bit   = |(w_dat_sh & c_dat_lsb);
  assign w_first_bit = |(w_first_sh & c_dat_lsb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ser   <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_port  <= '0;
      r_len   <= '0;
      r_data  <= '0;
`ifdef TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (Clk_EN) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_port  <= port_in;
              r_len   <= len_in;
              r_data  <= data_in;
              r_ser   <= 1'b0;
              r_ready <= 1'b0;
              r_state <= S_START;
`ifdef TX_PARITY_EN
              r_par   <= 1'b0;
`endif
            end
          end
          S_START: begin
            r_ser   <= r_port[1];
            r_cnt   <= c_one;
            r_state <= S_PORT;
          end
          S_PORT: begin
            if (r_cnt != '0) begin
              r_ser <= r_port[0];
              r_cnt <= '0;
            end else begin
              r_ser   <= r_len[CNT_W-1];
              r_cnt   <= c_len_top;
              r_state <= S_LEN;
            end
          end
          S_LEN: begin
            if (r_cnt != '0) begin
              r_ser <= w_len_bit;
              r_cnt <= w_idx;
            end else if (r_len != '0) begin
              r_ser   <= w_first_bit;
              r_cnt   <= r_len - c_one;
              r_state <= S_DATA;
`ifdef TX_PARITY_EN
              r_par   <= w_first_bit;
`endif
            end else begin
`ifdef TX_PARITY_EN
              r_ser   <= 1'b0;
              r_state <= S_PAR;
`else
              r_ser   <= 1'b1;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
`endif
            end
          end
          S_DATA: begin
            if (r_cnt != '0) begin
              r_ser <= w_dat_bit;
              r_cnt <= w_idx;
`ifdef TX_PARITY_EN
              r_par <= r_par ^ w_dat_bit;
`endif
            end else begin
`ifdef TX_PARITY_EN
              r_ser   <= r_par;
              r_state <= S_PAR;
`else
              r_ser   <= 1'b1;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
`endif
            end
          end
          S_PAR: begin
            r_ser   <= 1'b1;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            r_ser   <= 1'b1;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ready  = r_ready;
  assign busy   = ~r_ready;
  assign SerOut = r_ser;
  assign done   = r_done;

endmodule
`default_nettype wire
